// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared opcodes, state/class enums and datapath select
//                encodings for the multicycle RISC-V control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13,
        S_ILLEGAL  = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        CLS_LOAD    = 4'd0,
        CLS_STORE   = 4'd1,
        CLS_RTYPE   = 4'd2,
        CLS_ITYPE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_ILLEGAL = 4'd8
    } op_class_t;

    localparam logic [1:0] C_RES_ALUOUT = 2'b00;
    localparam logic [1:0] C_RES_DATA   = 2'b01;
    localparam logic [1:0] C_RES_ALURES = 2'b10;

    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_RD1   = 2'b10;
    localparam logic [1:0] C_SRCA_ZERO  = 2'b11;

    localparam logic [1:0] C_SRCB_RD2   = 2'b00;
    localparam logic [1:0] C_SRCB_IMM   = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR  = 2'b10;

    localparam logic [1:0] C_ALU_ADD    = 2'b00;
    localparam logic [1:0] C_ALU_SUB    = 2'b01;
    localparam logic [1:0] C_ALU_FUNCT  = 2'b10;

    localparam logic [2:0] C_IMM_I      = 3'b000;
    localparam logic [2:0] C_IMM_S      = 3'b001;
    localparam logic [2:0] C_IMM_B      = 3'b010;
    localparam logic [2:0] C_IMM_J      = 3'b011;
    localparam logic [2:0] C_IMM_U      = 3'b100;

endpackage

`default_nettype wire

// File: rtl/op_class_deco.sv
// ============================================================================
//  Module      : op_class_deco
//  Description : Combinational opcode classifier: instruction class,
//                immediate format and legality, with jalr/lui gating.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_class_deco #(
    parameter int EN_JALR = 1,
    parameter int EN_LUI  = 1
) (
    input  logic [6:0] op,
    output logic [3:0] op_class,
    output logic [2:0] imm_src,
    output logic       legal
);
    import ctrl_pkg::*;

    op_class_t w_class;

    always_comb begin
        w_class = CLS_ILLEGAL;
        imm_src = C_IMM_I;
        case (op)
            C_OP_LOAD:   w_class = CLS_LOAD;
            C_OP_STORE:  begin w_class = CLS_STORE;  imm_src = C_IMM_S; end
            C_OP_RTYPE:  w_class = CLS_RTYPE;
            C_OP_ITYPE:  w_class = CLS_ITYPE;
            C_OP_BRANCH: begin w_class = CLS_BRANCH; imm_src = C_IMM_B; end
            C_OP_JAL:    begin w_class = CLS_JAL;    imm_src = C_IMM_J; end
            C_OP_JALR:   if (EN_JALR != 0) w_class = CLS_JALR;
            // A disabled lui is treated exactly like an unknown opcode.
            C_OP_LUI:    if (EN_LUI != 0) begin w_class = CLS_LUI; imm_src = C_IMM_U; end
            default:     w_class = CLS_ILLEGAL;
        endcase
    end

    assign op_class = w_class;
    assign legal    = (w_class != CLS_ILLEGAL);

endmodule

`default_nettype wire

// File: rtl/main_fsm.sv
// ============================================================================
//  Module      : main_fsm
//  Description : Multicycle RISC-V control FSM: sequences each instruction
//                over 3-5 cycles with memory wait states and branch resolve.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_fsm #(
    parameter int MEM_WAIT        = 1,
    parameter int TRAP_ON_ILLEGAL = 0,
    parameter int EN_JALR         = 1,
    parameter int EN_LUI          = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       illegal
);
    import ctrl_pkg::*;

    state_t     r_state;
    state_t     w_next;
    op_class_t  w_class;
    logic [3:0] w_class_raw;
    logic       w_legal;
    logic       w_ready;
    logic       w_unused_funct3;

    assign w_ready         = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign w_class         = op_class_t'(w_class_raw);
    assign w_unused_funct3 = ^funct3[2:1];

    op_class_deco #(
        .EN_JALR (EN_JALR),
        .EN_LUI  (EN_LUI)
    ) u_deco (
        .op       (op),
        .op_class (w_class_raw),
        .imm_src  (imm_src),
        .legal    (w_legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (w_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (!w_legal) w_next = S_ILLEGAL;
                else begin
                    case (w_class)
                        CLS_LOAD, CLS_STORE: w_next = S_MEMADR;
                        CLS_RTYPE:           w_next = S_EXECR;
                        CLS_ITYPE:           w_next = S_EXECI;
                        CLS_BRANCH:          w_next = S_BRANCH;
                        CLS_JAL:             w_next = S_JAL;
                        CLS_JALR:            w_next = S_JALR;
                        CLS_LUI:             w_next = S_LUI;
                        default:             w_next = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR:   w_next = (w_class == CLS_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (w_ready) w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: if (w_ready) w_next = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LINK, S_LUI: w_next = S_ALUWB;
            S_ALUWB, S_BRANCH: w_next = S_FETCH;
            S_JALR:     w_next = S_LINK;
            S_ILLEGAL:  w_next = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        result_src = C_RES_ALUOUT;
        alu_src_a  = C_SRCA_PC;
        alu_src_b  = C_SRCB_RD2;
        alu_op     = C_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = C_SRCB_FOUR;
                result_src = C_RES_ALURES;
                ir_write   = w_ready;
                pc_write   = w_ready;
            end
            S_DECODE:   begin alu_src_a = C_SRCA_OLDPC; alu_src_b = C_SRCB_IMM; end
            S_MEMADR:   begin alu_src_a = C_SRCA_RD1;   alu_src_b = C_SRCB_IMM; end
            S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
            S_MEMWB:    begin result_src = C_RES_DATA; reg_write = 1'b1; end
            S_MEMWRITE: begin mem_req = 1'b1; adr_src = 1'b1; mem_write = 1'b1; end
            S_EXECR:    begin alu_src_a = C_SRCA_RD1; alu_op = C_ALU_FUNCT; end
            S_EXECI: begin
                alu_src_a = C_SRCA_RD1;
                alu_src_b = C_SRCB_IMM;
                alu_op    = C_ALU_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = C_SRCA_RD1;
                alu_op    = C_ALU_SUB;
                pc_write  = zero ^ funct3[0];
            end
            S_JAL:      begin alu_src_a = C_SRCA_OLDPC; alu_src_b = C_SRCB_FOUR; pc_write = 1'b1; end
            S_JALR: begin
                alu_src_a  = C_SRCA_RD1;
                alu_src_b  = C_SRCB_IMM;
                result_src = C_RES_ALURES;
                pc_write   = 1'b1;
            end
            S_LINK:     begin alu_src_a = C_SRCA_OLDPC; alu_src_b = C_SRCB_FOUR; end
            S_LUI:      begin alu_src_a = C_SRCA_ZERO;  alu_src_b = C_SRCB_IMM; end
            S_ILLEGAL, S_TRAP: illegal = 1'b1;
            default: ;
        endcase
        // Reset holds the state at FETCH but must not let FETCH strobes escape.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_req   = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_main_fsm.sv
// ============================================================================
//  Module      : tb_main_fsm
//  Description : Directed self-checking bench for main_fsm (default build
//                plus a trap-on-illegal, lui-disabled build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_fsm;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // Vector order: pcw adr irw req mw rw | rs[2] a[2] b[2] aop[2] | ill
    localparam logic [14:0] E_RST   = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] E_FETCH = 15'b1_0_1_1_0_0_10_00_10_00_0;
    localparam logic [14:0] E_FWAIT = 15'b0_0_0_1_0_0_10_00_10_00_0;
    localparam logic [14:0] E_DEC   = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] E_MADR  = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] E_MRD   = 15'b0_1_0_1_0_0_00_00_00_00_0;
    localparam logic [14:0] E_MWB   = 15'b0_0_0_0_0_1_01_00_00_00_0;
    localparam logic [14:0] E_MWR   = 15'b0_1_0_1_1_0_00_00_00_00_0;
    localparam logic [14:0] E_EXR   = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] E_EXI   = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] E_AWB   = 15'b0_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] E_BRT   = 15'b1_0_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] E_BRN   = 15'b0_0_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] E_JAL   = 15'b1_0_0_0_0_0_00_01_10_00_0;
    localparam logic [14:0] E_JALR  = 15'b1_0_0_0_0_0_10_10_01_00_0;
    localparam logic [14:0] E_LINK  = 15'b0_0_0_0_0_0_00_01_10_00_0;
    localparam logic [14:0] E_LUI   = 15'b0_0_0_0_0_0_00_11_01_00_0;
    localparam logic [14:0] E_ILL   = 15'b0_0_0_0_0_0_00_00_00_00_1;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       pcw0, adr0, irw0, req0, mw0, rw0, ill0;
    logic [1:0] rs0, a0, b0, aop0;
    logic [2:0] imm0;
    logic       pcw1, adr1, irw1, req1, mw1, rw1, ill1;
    logic [1:0] rs1, a1, b1, aop1;
    logic [2:0] imm1;

    logic [14:0] obs0, obs1;
    assign obs0 = {pcw0, adr0, irw0, req0, mw0, rw0, rs0, a0, b0, aop0, ill0};
    assign obs1 = {pcw1, adr1, irw1, req1, mw1, rw1, rs1, a1, b1, aop1, ill1};

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    main_fsm u_dut0 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pcw0), .adr_src(adr0), .ir_write(irw0),
        .mem_req(req0), .mem_write(mw0), .reg_write(rw0), .result_src(rs0),
        .alu_src_a(a0), .alu_src_b(b0), .alu_op(aop0), .imm_src(imm0), .illegal(ill0)
    );

    main_fsm #(.MEM_WAIT(1), .TRAP_ON_ILLEGAL(1), .EN_JALR(1), .EN_LUI(0)) u_dut1 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pcw1), .adr_src(adr1), .ir_write(irw1),
        .mem_req(req1), .mem_write(mw1), .reg_write(rw1), .result_src(rs1),
        .alu_src_a(a1), .alu_src_b(b1), .alu_op(aop1), .imm_src(imm1), .illegal(ill1)
    );

    task automatic chk(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    endtask

    task automatic chk_imm(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; op = OP_LW; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
        step();
        chk("reset_d0", obs0, E_RST);
        chk("reset_d1", obs1, E_RST);
        @(negedge clk); reset = 1'b0; #1;

        // lw with two wait cycles in MEMREAD: 7 cycles total
        chk("lw_fetch", obs0, E_FETCH);
        step(); chk("lw_decode", obs0, E_DEC); chk_imm("lw_imm", imm0, 3'b000);
        step(); chk("lw_memadr", obs0, E_MADR); mem_ready = 1'b0;
        step(); chk("lw_memread1", obs0, E_MRD);
        step(); chk("lw_memread2", obs0, E_MRD);
        step(); mem_ready = 1'b1; chk("lw_memread3", obs0, E_MRD);
        step(); chk("lw_memwb", obs0, E_MWB);
        step(); chk("lw_done", obs0, E_FETCH);

        op = OP_SW;
        step(); chk("sw_decode", obs0, E_DEC); chk_imm("sw_imm", imm0, 3'b001);
        step(); chk("sw_memadr", obs0, E_MADR);
        step(); chk("sw_memwrite", obs0, E_MWR);
        step(); chk("sw_done", obs0, E_FETCH);

        op = OP_R;
        step(); chk("r_decode", obs0, E_DEC);
        step(); chk("r_exec", obs0, E_EXR);
        step(); chk("r_aluwb", obs0, E_AWB);
        step(); chk("r_done", obs0, E_FETCH);

        op = OP_I;
        step(); chk("i_decode", obs0, E_DEC);
        step(); chk("i_exec", obs0, E_EXI);
        step(); chk("i_aluwb", obs0, E_AWB);
        step(); chk("i_done", obs0, E_FETCH);

        op = OP_BR; zero = 1'b1; funct3 = 3'b000;
        step(); chk("beq_decode", obs0, E_DEC); chk_imm("beq_imm", imm0, 3'b010);
        step(); chk("beq_taken", obs0, E_BRT);
        step(); chk("beq_done", obs0, E_FETCH);

        funct3 = 3'b001;
        step(); chk("bne_decode", obs0, E_DEC);
        step(); chk("bne_not_taken", obs0, E_BRN);
        step(); chk("bne_done", obs0, E_FETCH);
        funct3 = 3'b000; zero = 1'b0;

        op = OP_JAL;
        step(); chk("jal_decode", obs0, E_DEC); chk_imm("jal_imm", imm0, 3'b011);
        step(); chk("jal_jal", obs0, E_JAL);
        step(); chk("jal_aluwb", obs0, E_AWB);
        step(); chk("jal_done", obs0, E_FETCH);

        op = OP_JALR;
        step(); chk("jalr_decode", obs0, E_DEC); chk_imm("jalr_imm", imm0, 3'b000);
        step(); chk("jalr_jalr", obs0, E_JALR);
        step(); chk("jalr_link", obs0, E_LINK);
        step(); chk("jalr_aluwb", obs0, E_AWB);
        step(); chk("jalr_done", obs0, E_FETCH);

        // op 0: one-cycle pulse on the default build, trap on the other
        op = 7'b0000000;
        step(); chk("ill_decode", obs0, E_DEC); chk_imm("ill_imm", imm0, 3'b000);
        step(); chk("ill_pulse", obs0, E_ILL); chk("ill_d1", obs1, E_ILL);
        step(); chk("ill_back_fetch", obs0, E_FETCH); chk("trap_d1_a", obs1, E_ILL);
        mem_ready = 1'b0; #1;
        chk("fetch_wait1", obs0, E_FWAIT);
        step(); chk("fetch_wait2", obs0, E_FWAIT); chk("trap_d1_b", obs1, E_ILL);
        mem_ready = 1'b1; #1;
        chk("fetch_ready", obs0, E_FETCH);

        // reset during a stalled store
        op = OP_SW;
        step(); chk("swr_decode", obs0, E_DEC);
        step(); chk("swr_memadr", obs0, E_MADR); mem_ready = 1'b0;
        step(); chk("swr_memwrite1", obs0, E_MWR);
        step(); chk("swr_memwrite2", obs0, E_MWR);
        #2 reset = 1'b1; #1;
        chk("swr_reset_d0", obs0, E_RST);
        chk("swr_reset_d1", obs1, E_RST);
        @(negedge clk); reset = 1'b0; mem_ready = 1'b1; #1;
        chk("swr_fetch_d0", obs0, E_FETCH);
        chk("swr_fetch_d1", obs1, E_FETCH);

        // lui enabled on d0, disabled on d1
        op = OP_LUI;
        step(); chk("lui_decode", obs0, E_DEC); chk_imm("lui_imm", imm0, 3'b100);
        chk("lui_decode_d1", obs1, E_DEC);
        step(); chk("lui_lui", obs0, E_LUI); chk("lui_ill_d1", obs1, E_ILL);
        op = OP_LW;
        step(); chk("lui_aluwb", obs0, E_AWB); chk("lui_trap_d1_a", obs1, E_ILL);
        step(); chk("lui_done", obs0, E_FETCH); chk("lui_trap_d1_b", obs1, E_ILL);
        step(); chk("lw2_decode", obs0, E_DEC); chk("lui_trap_d1_c", obs1, E_ILL);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        chk("trap_exit_d1", obs1, E_FETCH);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RISC-V core; the sequential successor to the single-cycle main decoder. From the opcode it sequences each instruction over 3–5 cycles, driving datapath mux selects and write strobes, and resolves branches internally from the ALU zero flag. It adds a memory wait-state handshake, `bne`, `jalr` and `lui`, and a configurable illegal-opcode policy, all selected by parameters.

## Interface
Parameters:
- `MEM_WAIT`, default 1: 1 = honour `mem_ready`; 0 = treat `mem_ready` as constant 1.
- `TRAP_ON_ILLEGAL`, default 0: 1 = illegal opcode locks in TRAP; 0 = one-cycle `illegal` pulse, then FETCH.
- `EN_JALR`, default 1: 0 = opcode 1100111 is illegal.
- `EN_LUI`, default 1: 0 = opcode 0110111 is illegal.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `op` in 7: opcode from the instruction register.
- `funct3` in 3: only bit 0 is used (0 = beq, 1 = bne).
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access.
- `pc_write` out 1: PC load strobe.
- `adr_src` out 1: 0 = PC, 1 = Result.
- `ir_write` out 1: IR/OldPC load strobe.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: store enable.
- `reg_write` out 1: register file write strobe.
- `result_src` out 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: 00 = PC, 01 = OldPC, 10 = rd1, 11 = zero.
- `alu_src_b` out 2: 00 = rd2, 01 = ImmExt, 10 = constant 4.
- `alu_op` out 2: 00 = add, 01 = sub/compare, 10 = decode by funct.
- `imm_src` out 3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `illegal` out 1: unsupported opcode detected.

## Operation
`imm_src` is a combinational function of `op` in every state; unknown opcodes give 000.

Each state lists its outputs (unlisted selects are 00/0; strobes are 0 unless stated), then its transition.
- **FETCH**
  - Outputs: `mem_req`=1, `adr_src`=0, a=00, b=10, alu_op=00, result_src=10; `ir_write` = `pc_write` = `mem_ready`.
  - Transition: to DECODE on `mem_ready`, else hold.
- **DECODE**
  - Outputs: a=01, b=01, alu_op=00 (branch/jal target into ALUOut).
  - Transition by opcode:
    - lw/sw → MEMADR
    - R-type 0110011 → EXECR
    - I-ALU 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - anything else, or a disabled feature → ILLEGAL
- **MEMADR**
  - Outputs: a=10, b=01, alu_op=00.
  - Transition: lw → MEMREAD; sw → MEMWRITE.
- **MEMREAD**
  - Outputs: `mem_req`=1, `adr_src`=1.
  - Transition: to MEMWB on `mem_ready`.
- **MEMWB**
  - Outputs: result_src=01, `reg_write`=1.
  - Transition: to FETCH.
- **MEMWRITE**
  - Outputs: `mem_req`=1, `adr_src`=1, `mem_write`=1 held for the whole wait.
  - Transition: to FETCH on `mem_ready`.
- **EXECR**
  - Outputs: a=10, b=00, alu_op=10.
  - Transition: to ALUWB.
- **EXECI**
  - Outputs: a=10, b=01, alu_op=10.
  - Transition: to ALUWB.
- **ALUWB**
  - Outputs: result_src=00, `reg_write`=1.
  - Transition: to FETCH.
- **BRANCH**
  - Outputs: a=10, b=00, alu_op=01, result_src=00; `pc_write` = `zero` XOR `funct3[0]`.
  - Transition: to FETCH.
- **JAL**
  - Outputs: a=01, b=10, alu_op=00, result_src=00, `pc_write`=1.
  - Transition: to ALUWB (writes OldPC+4 as the link).
- **JALR**
  - Outputs: a=10, b=01, alu_op=00, result_src=10, `pc_write`=1.
  - Transition: to LINK.
- **LINK**
  - Outputs: a=01, b=10, alu_op=00.
  - Transition: to ALUWB.
- **LUI**
  - Outputs: a=11, b=01, alu_op=00.
  - Transition: to ALUWB.
- **ILLEGAL**
  - Outputs: `illegal`=1.
  - Transition: to FETCH if `TRAP_ON_ILLEGAL`=0; otherwise to TRAP.
- **TRAP**
  - Outputs: `illegal`=1, all strobes 0.
  - Transition: only `reset` exits.

## Timing
- Reset:
  - Asserting `reset` forces state to FETCH immediately.
  - While `reset` is high, every strobe (`pc_write`, `ir_write`, `reg_write`, `mem_write`, `mem_req`) and `illegal` is 0; mux selects take their FETCH values.
  - Reset mid-instruction abandons the instruction; no write strobe is issued afterwards.
- State register updates on the `clk` rising edge; `next_state` is registered, and outputs are combinational from state (plus `zero`, `mem_ready`).
- Latency with `mem_ready`=1, FETCH to next FETCH: lw 5, sw 4, R 4, I 4, branch 3, jal 4, jalr 5, lui 4 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle; outputs stay stable during the wait.
- `mem_ready` is ignored outside those three states.
- `illegal` lasts exactly one cycle when `TRAP_ON_ILLEGAL`=0.

## Structure
- Package `ctrl_pkg`: opcode constants, the state enum (4-bit), and encodings for result_src, alu_src_a, alu_src_b, alu_op and imm_src.
- Sub-module `op_class_deco` (combinational): `op` → class, `imm_src`, legal flag; parameters gate jalr/lui.
- `main_fsm` holds only the state register, next-state logic and output logic.

## Test plan
- lw with `mem_ready` low for 2 cycles in MEMREAD → 7 cycles total; `reg_write`=1 only in MEMWB with result_src=01.
- beq with `zero`=1 → `pc_write`=1 in BRANCH; bne (funct3=001) with `zero`=1 → `pc_write`=0; both take 3 cycles.
- jal → `pc_write` in FETCH and JAL, `reg_write` in ALUWB with result_src=00; jalr → states FETCH, DECODE, JALR, LINK, ALUWB.
- op=0000000 with `TRAP_ON_ILLEGAL`=0 → `illegal` for one cycle, then FETCH; with `TRAP_ON_ILLEGAL`=1 → `illegal` held and the FSM stays in TRAP until `reset`.
- `EN_LUI`=0, op=0110111 → ILLEGAL; `EN_LUI`=1 → a=11, b=01 in LUI, then `reg_write` in ALUWB.
- `reset` pulsed mid-MEMWRITE → strobes drop in the same cycle; after release, FETCH with `mem_write`=0.
